prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
- Top-level launch controller for the fetch unit. It drives the Start, Jump, BranchAbsOrRel and Target inputs of the program counter.
- Holds the PC between programs, then jumps it to the base address of the next program in the series.
- While a program runs, it forwards datapath branch requests to the fetch unit and counts run cycles.
- On halt or timeout, it reports completion and advances the program index.

Parameters:
- NUM_PROGS, 3, number of programs in the series (1..3)
- PW, 10, PC/target width
- CW, 16, cycle counter width
- PROG0_BASE, 10'd0, absolute start address of program 0
- PROG1_BASE, 10'd256, absolute start address of program 1
- PROG2_BASE, 10'd512, absolute start address of program 2
- MAX_CYCLES, 16'hFFFF, run-cycle limit before forced timeout

Ports:
- Clk  in  1  clock; all state changes on posedge
- Reset  in  1  asynchronous, active-high; forces reset state immediately
- Go  in  1  request to launch the next program; level-sampled
- Halt  in  1  datapath has decoded the program-end instruction
- BrTaken  in  1  datapath branch/jump taken this cycle
- BrRel  in  1  1 = relative (PC+target), 0 = absolute
- BrTarget  in  PW  datapath branch target/offset
- Start  out  1  to fetch unit: hold PC
- Jump  out  1  to fetch unit: load/offset PC
- BranchAbsOrRel  out  1  to fetch unit: 0 = absolute, 1 = relative
- Target  out  PW  to fetch unit: jump target
- Busy  out  1  a program is being launched or run
- Done  out  1  one-cycle pulse at program completion
- Timeout  out  1  last program ended by cycle limit, not Halt
- AllDone  out  1  all NUM_PROGS programs completed
- ProgNum  out  2  index of the next (or current) program
- CycleCnt  out  CW  run cycles of the current or last program

Behaviour:
- States: IDLE, LOAD, RUN, DONE. State is registered; outputs are decoded from state, except the RUN branch passthrough.
- Reset (async) values:
  - State = IDLE, ProgNum = 0, CycleCnt = 0, Timeout = 0.
  - Resulting outputs: Done = 0, Busy = 0, Start = 1, Jump = 0, BranchAbsOrRel = 0, Target = 0.
- Reset asserted mid-RUN aborts the program immediately. The cycle count and program index are lost.
- IDLE:
  - Outputs: Start = 1, Jump = 0, Busy = 0.
  - Go = 1 and ProgNum < NUM_PROGS -> LOAD.
  - Go while AllDone is ignored.
- LOAD (exactly 1 cycle):
  - Outputs: Start = 0, Jump = 1, BranchAbsOrRel = 0, Target = base[ProgNum], Busy = 1.
  - CycleCnt <= 0 and Timeout <= 0.
  - Next state RUN; the PC equals the base address on RUN's first cycle.
- RUN:
  - Static outputs: Start = 0, Busy = 1.
  - Branch passthrough (combinational, zero latency): Jump = BrTaken & ~Halt, BranchAbsOrRel = BrRel, Target = BrTarget.
  - CycleCnt increments each RUN cycle, including the Halt cycle, and saturates at all-ones.
  - Halt = 1 -> DONE, Timeout <= 0. Halt has priority over BrTaken in the same cycle.
  - Halt = 0 and CycleCnt == MAX_CYCLES-1 -> DONE, Timeout <= 1.
- DONE (exactly 1 cycle):
  - Outputs: Start = 1, Jump = 0, Done = 1, Busy = 0.
  - ProgNum <= ProgNum + 1, saturating at NUM_PROGS.
  - Next state IDLE.
- In DONE and IDLE, CycleCnt and Timeout hold their last values until the next LOAD.
- AllDone = (ProgNum == NUM_PROGS). It is combinational from ProgNum and is cleared only by Reset.
- Go is ignored in LOAD, RUN and DONE. A Go held high across DONE relaunches from IDLE on the following cycle. The minimum gap between programs is 1 IDLE cycle.
- Unused base parameters (index >= NUM_PROGS) are never selected. Target = base[ProgNum] uses PW-bit values with no arithmetic.
- Halt and BrTaken are ignored outside RUN.

Test Plan:
- Reset then Go pulse; Halt on the 5th RUN cycle -> LOAD drives Jump = 1, Target = 0, BranchAbsOrRel = 0; Done pulses 1 cycle; CycleCnt = 5; ProgNum = 1; Start = 1 thereafter.
- Run three programs back-to-back with Go held high -> Targets 0, 256, 512 in successive LOADs; AllDone = 1 after the third Done; a further Go leaves the state in IDLE.
- In RUN, BrTaken = 1, BrRel = 1, BrTarget = 10'h3FC -> same cycle Jump = 1, BranchAbsOrRel = 1, Target = 10'h3FC. With Halt = 1 in the same cycle, Jump = 0 and the state goes to DONE.
- MAX_CYCLES = 8, Halt never asserted -> DONE after the 8th RUN cycle; CycleCnt = 8; Timeout = 1; the next LOAD clears Timeout.
- Assert Reset asynchronously (between edges) mid-RUN -> outputs return to reset values before the next Clk edge; ProgNum = 0; the next Go relaunches program 0 at Target 0.
- Go asserted during RUN or DONE -> no extra LOAD; exactly one Done per launch.

Source files
------------

// File: rtl/prog_sequencer.sv
// Launch controller for the fetch unit: steps through up to three programs,
// jumps the PC to each program's base, forwards branches while running and times runs out.
module prog_sequencer #(
   parameter int              NUM_PROGS  = 3,
   parameter int              PW         = 10,
   parameter int              CW         = 16,
   parameter logic [PW-1:0]   PROG0_BASE = 10'd0,
   parameter logic [PW-1:0]   PROG1_BASE = 10'd256,
   parameter logic [PW-1:0]   PROG2_BASE = 10'd512,
   parameter logic [CW-1:0]   MAX_CYCLES = 16'hFFFF
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           Go,
   input  logic           Halt,
   input  logic           BrTaken,
   input  logic           BrRel,
   input  logic [PW-1:0]  BrTarget,
   output logic           Start,
   output logic           Jump,
   output logic           BranchAbsOrRel,
   output logic [PW-1:0]  Target,
   output logic           Busy,
   output logic           Done,
   output logic           Timeout,
   output logic           AllDone,
   output logic [1:0]     ProgNum,
   output logic [CW-1:0]  CycleCnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [1:0]    LAST_PROG = 2'(NUM_PROGS);
   localparam logic [CW-1:0] CNT_LIMIT = MAX_CYCLES - CW'(1);
   localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};

   logic [1:0]    state_q, state_d;
   logic [1:0]    prog_num_q, prog_num_d;
   logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
   logic          timeout_q, timeout_d;

   function automatic logic [PW-1:0] base_of(input logic [1:0] idx);
      case (idx)
         2'd0:    base_of = PROG0_BASE;
         2'd1:    base_of = PROG1_BASE;
         2'd2:    base_of = PROG2_BASE;
         default: base_of = {PW{1'b0}};
      endcase
   endfunction

   // Next-state, program index, run-cycle counter and timeout flag.
   always_comb begin
      state_d     = state_q;
      prog_num_d  = prog_num_q;
      cycle_cnt_d = cycle_cnt_q;
      timeout_d   = timeout_q;
      case (state_q)
         S_IDLE: begin
            if (Go && (prog_num_q < LAST_PROG)) begin
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            state_d     = S_RUN;
            cycle_cnt_d = {CW{1'b0}};
            timeout_d   = 1'b0;
         end
         S_RUN: begin
            if (cycle_cnt_q != CNT_SAT) begin
               cycle_cnt_d = cycle_cnt_q + CW'(1);
            end else begin
               cycle_cnt_d = cycle_cnt_q;
            end
            // Halt wins over the limit so a program ending on its last allowed cycle is not a timeout.
            if (Halt) begin
               state_d   = S_DONE;
               timeout_d = 1'b0;
            end else if (cycle_cnt_q == CNT_LIMIT) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end else begin
               state_d   = S_RUN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (prog_num_q != LAST_PROG) begin
               prog_num_d = prog_num_q + 2'd1;
            end else begin
               prog_num_d = prog_num_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         prog_num_q  <= 2'd0;
         cycle_cnt_q <= {CW{1'b0}};
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         prog_num_q  <= prog_num_d;
         cycle_cnt_q <= cycle_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   // Fetch-unit controls decoded from state; RUN passes branches straight through.
   always_comb begin
      Start          = 1'b1;
      Jump           = 1'b0;
      BranchAbsOrRel = 1'b0;
      Target         = {PW{1'b0}};
      Busy           = 1'b0;
      Done           = 1'b0;
      case (state_q)
         S_IDLE: begin
            Start = 1'b1;
         end
         S_LOAD: begin
            Start  = 1'b0;
            Jump   = 1'b1;
            Target = base_of(prog_num_q);
            Busy   = 1'b1;
         end
         S_RUN: begin
            Start          = 1'b0;
            Busy           = 1'b1;
            Jump           = BrTaken & ~Halt;
            BranchAbsOrRel = BrRel;
            Target         = BrTarget;
         end
         S_DONE: begin
            Done = 1'b1;
         end
         default: begin
            Start = 1'b1;
         end
      endcase
   end

   assign Timeout  = timeout_q;
   assign CycleCnt = cycle_cnt_q;
   assign ProgNum  = prog_num_q;
   assign AllDone  = (prog_num_q == LAST_PROG);

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized self-checking bench for prog_sequencer, run with a cycle limit of 8
// so that timeouts are reachable; expectations come from a per-program model.
module tb_prog_sequencer;

   localparam int NPROG = 3;
   localparam int MAXC  = 8;

   logic        Clk = 1'b0;
   logic        Reset, Go, Halt, BrTaken, BrRel;
   logic [9:0]  BrTarget;
   logic        Start, Jump, BranchAbsOrRel, Busy, Done, Timeout, AllDone;
   logic [9:0]  Target;
   logic [1:0]  ProgNum;
   logic [15:0] CycleCnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: per-program results, not cycle states.
   int          m_prog = 0;
   int          m_cnt  = 0;
   bit          m_to   = 1'b0;
   logic [9:0]  base_tbl [3] = '{10'd0, 10'd256, 10'd512};

   prog_sequencer #(.MAX_CYCLES(16'd8)) dut (
      .Clk(Clk), .Reset(Reset), .Go(Go), .Halt(Halt), .BrTaken(BrTaken),
      .BrRel(BrRel), .BrTarget(BrTarget), .Start(Start), .Jump(Jump),
      .BranchAbsOrRel(BranchAbsOrRel), .Target(Target), .Busy(Busy),
      .Done(Done), .Timeout(Timeout), .AllDone(AllDone), .ProgNum(ProgNum),
      .CycleCnt(CycleCnt)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic rand_misc();
      Halt     = 1'($urandom);
      BrTaken  = 1'($urandom);
      BrRel    = 1'($urandom);
      BrTarget = 10'($urandom);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_start"}, 32'(Start), 32'd1);
      chk({tag, "_jump"}, 32'(Jump), 32'd0);
      chk({tag, "_rel"}, 32'(BranchAbsOrRel), 32'd0);
      chk({tag, "_target"}, 32'(Target), 32'd0);
      chk({tag, "_busy"}, 32'(Busy), 32'd0);
      chk({tag, "_done"}, 32'(Done), 32'd0);
      chk({tag, "_timeout"}, 32'(Timeout), 32'd0);
      chk({tag, "_prognum"}, 32'(ProgNum), 32'd0);
      chk({tag, "_cyclecnt"}, 32'(CycleCnt), 32'd0);
      chk({tag, "_alldone"}, 32'(AllDone), 32'd0);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      #1;
      chk_reset_outputs("rst");
      tick();
      Reset = 1'b0;
      m_prog = 0; m_cnt = 0; m_to = 1'b0;
      #1;
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         Go = 1'b0;
         rand_misc();
         #1;
         chk("gap_start", 32'(Start), 32'd1);
         chk("gap_busy", 32'(Busy), 32'd0);
         chk("gap_done", 32'(Done), 32'd0);
      end
   endtask

   // One launch attempt from IDLE; halt_at beyond MAXC means the run times out.
   task automatic launch(input int halt_at, input bit directed);
      int idx = m_prog;
      Go = 1'b1;
      rand_misc();
      #1;
      chk("idle_start", 32'(Start), 32'd1);
      chk("idle_jump", 32'(Jump), 32'd0);
      chk("idle_alldone", 32'(AllDone), 32'(idx == NPROG));
      if (idx >= NPROG) begin
         for (int i = 0; i < 3; i++) begin
            tick();
            Go = 1'b1;
            rand_misc();
            #1;
            chk("alldone_busy", 32'(Busy), 32'd0);
            chk("alldone_start", 32'(Start), 32'd1);
            chk("alldone_jump", 32'(Jump), 32'd0);
            chk("alldone_done", 32'(Done), 32'd0);
            chk("alldone_prognum", 32'(ProgNum), 32'(NPROG));
            chk("alldone_cnt", 32'(CycleCnt), 32'(m_cnt));
            chk("alldone_to", 32'(Timeout), 32'(m_to));
         end
         Go = 1'b0;
         return;
      end
      tick();
      Go = 1'($urandom);
      rand_misc();
      #1;
      chk("load_jump", 32'(Jump), 32'd1);
      chk("load_start", 32'(Start), 32'd0);
      chk("load_rel", 32'(BranchAbsOrRel), 32'd0);
      chk("load_target", 32'(Target), 32'(base_tbl[idx]));
      chk("load_busy", 32'(Busy), 32'd1);
      chk("load_done", 32'(Done), 32'd0);
      for (int k = 1; k <= MAXC; k++) begin
         tick();
         Go = 1'($urandom);
         rand_misc();
         Halt = (k == halt_at);
         if (directed && (k == 2 || k == halt_at)) begin
            BrTaken = 1'b1; BrRel = 1'b1; BrTarget = 10'h3FC;
         end
         #1;
         chk("run_start", 32'(Start), 32'd0);
         chk("run_busy", 32'(Busy), 32'd1);
         chk("run_done", 32'(Done), 32'd0);
         chk("run_jump", 32'(Jump), 32'(BrTaken && !Halt));
         chk("run_rel", 32'(BranchAbsOrRel), 32'(BrRel));
         chk("run_target", 32'(Target), 32'(BrTarget));
         chk("run_cnt", 32'(CycleCnt), 32'(k - 1));
         chk("run_to", 32'(Timeout), 32'd0);
         if (k == halt_at) break;
      end
      if (halt_at >= 1 && halt_at <= MAXC) begin
         m_cnt = halt_at; m_to = 1'b0;
      end else begin
         m_cnt = MAXC; m_to = 1'b1;
      end
      tick();
      Go = 1'($urandom);
      rand_misc();
      #1;
      chk("done_pulse", 32'(Done), 32'd1);
      chk("done_start", 32'(Start), 32'd1);
      chk("done_busy", 32'(Busy), 32'd0);
      chk("done_jump", 32'(Jump), 32'd0);
      chk("done_cnt", 32'(CycleCnt), 32'(m_cnt));
      chk("done_to", 32'(Timeout), 32'(m_to));
      chk("done_prognum", 32'(ProgNum), 32'(idx));
      m_prog = (idx + 1 > NPROG) ? NPROG : idx + 1;
      tick();
      Go = 1'b0;
      rand_misc();
      #1;
      chk("post_done", 32'(Done), 32'd0);
      chk("post_busy", 32'(Busy), 32'd0);
      chk("post_prognum", 32'(ProgNum), 32'(m_prog));
      chk("post_alldone", 32'(AllDone), 32'(m_prog == NPROG));
      chk("post_cnt", 32'(CycleCnt), 32'(m_cnt));
      chk("post_to", 32'(Timeout), 32'(m_to));
   endtask

   // Launch, run a few cycles, then hit Reset between clock edges.
   task automatic abort_run(input int run_cycles);
      Go = 1'b1;
      #1;
      tick();
      Go = 1'b0;
      for (int k = 0; k < run_cycles; k++) begin
         tick();
         Halt = 1'b0; BrTaken = 1'b1; BrRel = 1'b1; BrTarget = 10'h3FC;
         #1;
         chk("abort_run_busy", 32'(Busy), 32'd1);
      end
      #2;
      Reset = 1'b1;
      #1;
      chk_reset_outputs("async_rst");
      tick();
      Reset = 1'b0;
      m_prog = 0; m_cnt = 0; m_to = 1'b0;
      rand_misc();
      #1;
   endtask

   initial begin
      Reset = 1'b1; Go = 1'b0; Halt = 1'b0; BrTaken = 1'b0; BrRel = 1'b0; BrTarget = 10'd0;
      repeat (2) @(posedge Clk);
      do_reset();

      launch(5, 1'b0);          // halt on 5th run cycle
      launch(3, 1'b1);          // branch passthrough, halt with branch
      launch(9, 1'b0);          // no halt: timeout after 8 cycles
      launch(2, 1'b0);          // AllDone: Go ignored

      do_reset();
      launch(8, 1'b0);          // halt on the last allowed cycle
      abort_run(3);
      launch(4, 1'b1);          // relaunch program 0 after abort

      for (int it = 0; it < 30; it++) begin
         if (m_prog == NPROG && ($urandom % 2) == 0) do_reset();
         idle_gap($urandom_range(0, 2));
         launch($urandom_range(1, 10), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
